// File: rtl/ls_queue_param.sv
// In-order load/store queue: buffers memory ops in program order, snoops the CDB
// for operands, and offers the head to the memory unit (stores wait for commit).
module ls_queue_param #(
  parameter int DEPTH     = 8,
  parameter int XLEN      = 32,
  parameter int TAG_W     = 5,
  parameter int CDB_PORTS = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic                       disp_is_load,
  input  logic [TAG_W-1:0]           disp_tag,
  input  logic [XLEN-1:0]            disp_imm,
  input  logic [TAG_W-1:0]           disp_src1_tag,
  input  logic                       disp_src1_rdy,
  input  logic [XLEN-1:0]            disp_src1_val,
  input  logic [TAG_W-1:0]           disp_src2_tag,
  input  logic                       disp_src2_rdy,
  input  logic [XLEN-1:0]            disp_src2_val,
  input  logic [CDB_PORTS-1:0]       cdb_valid,
  input  logic [CDB_PORTS*TAG_W-1:0] cdb_tag,
  input  logic [CDB_PORTS*XLEN-1:0]  cdb_data,
  input  logic                       commit_valid,
  input  logic [TAG_W-1:0]           commit_tag,
  output logic                       iss_valid,
  input  logic                       iss_ready,
  output logic                       iss_is_load,
  output logic [TAG_W-1:0]           iss_tag,
  output logic [XLEN-1:0]            iss_addr,
  output logic [XLEN-1:0]            iss_data,
  input  logic                       mem_done,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0] e_valid;
  logic [DEPTH-1:0] e_is_load;
  logic [DEPTH-1:0] e_committed;
  logic [DEPTH-1:0] e_issued;
  logic [DEPTH-1:0] e_src1_rdy;
  logic [DEPTH-1:0] e_src2_rdy;
  logic [TAG_W-1:0] e_tag      [DEPTH];
  logic [TAG_W-1:0] e_src1_tag [DEPTH];
  logic [TAG_W-1:0] e_src2_tag [DEPTH];
  logic [XLEN-1:0]  e_imm      [DEPTH];
  logic [XLEN-1:0]  e_src1_val [DEPTH];
  logic [XLEN-1:0]  e_src2_val [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] cnt;

  logic [DEPTH-1:0] w1_hit;
  logic [DEPTH-1:0] w2_hit;
  logic [XLEN-1:0]  w1_val [DEPTH];
  logic [XLEN-1:0]  w2_val [DEPTH];
  logic             d1_hit;
  logic             d2_hit;
  logic [XLEN-1:0]  d1_val;
  logic [XLEN-1:0]  d2_val;

  logic disp_fire;
  logic iss_fire;
  logic retire;

  // Scanning from the highest port down lets the lowest matching port win.
  function automatic logic [XLEN:0] cdb_match(input logic [TAG_W-1:0] t);
    logic [XLEN:0] r;
    r = '0;
    for (int p = CDB_PORTS - 1; p >= 0; p--) begin
      if (cdb_valid[p] && (cdb_tag[p*TAG_W +: TAG_W] == t)) begin
        r = {1'b1, cdb_data[p*XLEN +: XLEN]};
      end
    end
    return r;
  endfunction

  always_comb begin
    w1_hit = '0;
    w2_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      {w1_hit[i], w1_val[i]} = cdb_match(e_src1_tag[i]);
      {w2_hit[i], w2_val[i]} = cdb_match(e_src2_tag[i]);
    end
    {d1_hit, d1_val} = cdb_match(disp_src1_tag);
    {d2_hit, d2_val} = cdb_match(disp_src2_tag);
  end

  assign disp_ready = (cnt != CNT_W'(DEPTH));
  assign empty      = (cnt == '0);
  assign count      = cnt;
  assign disp_fire  = disp_valid && disp_ready;

  assign iss_valid = e_valid[head] && !e_issued[head] && e_src1_rdy[head] &&
                     (e_is_load[head] || (e_src2_rdy[head] && e_committed[head]));
  assign iss_fire  = iss_valid && iss_ready;
  // A head accepted this very cycle may also retire this cycle.
  assign retire    = mem_done && e_valid[head] && (e_issued[head] || iss_fire);

  assign iss_is_load = iss_valid && e_is_load[head];
  assign iss_tag     = iss_valid ? e_tag[head] : '0;
  assign iss_addr    = iss_valid ? (e_src1_val[head] + e_imm[head]) : '0;
  assign iss_data    = (iss_valid && !e_is_load[head]) ? e_src2_val[head] : '0;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      e_valid     <= '0;
      e_issued    <= '0;
      e_committed <= '0;
      head        <= '0;
      tail        <= '0;
      cnt         <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (e_valid[i]) begin
          if (!e_src1_rdy[i] && w1_hit[i]) begin
            e_src1_rdy[i] <= 1'b1;
            e_src1_val[i] <= w1_val[i];
          end
          if (!e_src2_rdy[i] && w2_hit[i]) begin
            e_src2_rdy[i] <= 1'b1;
            e_src2_val[i] <= w2_val[i];
          end
          if (commit_valid && !e_is_load[i] && (e_tag[i] == commit_tag)) begin
            e_committed[i] <= 1'b1;
          end
        end
      end

      if (iss_fire) begin
        e_issued[head] <= 1'b1;
      end

      if (retire) begin
        e_valid[head]     <= 1'b0;
        e_issued[head]    <= 1'b0;
        e_committed[head] <= 1'b0;
        head              <= head + 1'b1;
      end

      // The tail slot is free whenever dispatch fires, so no per-entry update collides.
      if (disp_fire) begin
        e_valid[tail]     <= 1'b1;
        e_is_load[tail]   <= disp_is_load;
        e_tag[tail]       <= disp_tag;
        e_imm[tail]       <= disp_imm;
        e_committed[tail] <= 1'b0;
        e_issued[tail]    <= 1'b0;
        e_src1_tag[tail]  <= disp_src1_tag;
        e_src1_rdy[tail]  <= disp_src1_rdy || d1_hit;
        e_src1_val[tail]  <= (!disp_src1_rdy && d1_hit) ? d1_val : disp_src1_val;
        e_src2_tag[tail]  <= disp_src2_tag;
        e_src2_rdy[tail]  <= disp_is_load || disp_src2_rdy || d2_hit;
        e_src2_val[tail]  <= (!disp_src2_rdy && d2_hit) ? d2_val : disp_src2_val;
        tail              <= tail + 1'b1;
      end

      cnt <= cnt + CNT_W'(disp_fire) - CNT_W'(retire);
    end
  end

endmodule

// File: tb/tb_ls_queue_param.sv
// Bench for ls_queue_param: directed scenarios plus random traffic, all checked
// every cycle against a queue-based behavioural model.
module tb_ls_queue_param;

  localparam int DEPTH     = 8;
  localparam int XLEN      = 32;
  localparam int TAG_W     = 5;
  localparam int CDB_PORTS = 2;
  localparam int CNT_W     = $clog2(DEPTH) + 1;

  logic                       clk = 1'b0;
  logic                       reset, flush;
  logic                       disp_valid, disp_ready, disp_is_load;
  logic [TAG_W-1:0]           disp_tag, disp_src1_tag, disp_src2_tag;
  logic [XLEN-1:0]            disp_imm, disp_src1_val, disp_src2_val;
  logic                       disp_src1_rdy, disp_src2_rdy;
  logic [CDB_PORTS-1:0]       cdb_valid;
  logic [CDB_PORTS*TAG_W-1:0] cdb_tag;
  logic [CDB_PORTS*XLEN-1:0]  cdb_data;
  logic                       commit_valid;
  logic [TAG_W-1:0]           commit_tag;
  logic                       iss_valid, iss_ready, iss_is_load;
  logic [TAG_W-1:0]           iss_tag;
  logic [XLEN-1:0]            iss_addr, iss_data;
  logic                       mem_done;
  logic [CNT_W-1:0]           count;
  logic                       empty;

  logic             cv [CDB_PORTS];
  logic [TAG_W-1:0] ct [CDB_PORTS];
  logic [XLEN-1:0]  cd [CDB_PORTS];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  ls_queue_param #(.DEPTH(DEPTH), .XLEN(XLEN), .TAG_W(TAG_W), .CDB_PORTS(CDB_PORTS)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_is_load(disp_is_load),
    .disp_tag(disp_tag), .disp_imm(disp_imm),
    .disp_src1_tag(disp_src1_tag), .disp_src1_rdy(disp_src1_rdy), .disp_src1_val(disp_src1_val),
    .disp_src2_tag(disp_src2_tag), .disp_src2_rdy(disp_src2_rdy), .disp_src2_val(disp_src2_val),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .commit_valid(commit_valid), .commit_tag(commit_tag),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_is_load(iss_is_load),
    .iss_tag(iss_tag), .iss_addr(iss_addr), .iss_data(iss_data),
    .mem_done(mem_done), .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int p = 0; p < CDB_PORTS; p++) begin
      cdb_valid[p]                 = cv[p];
      cdb_tag[p*TAG_W +: TAG_W]    = ct[p];
      cdb_data[p*XLEN +: XLEN]     = cd[p];
    end
  end

  // Reference model: the queue contents in program order, head at index 0.
  typedef struct {
    bit             is_load;
    bit [TAG_W-1:0] tag;
    bit [XLEN-1:0]  imm;
    bit [TAG_W-1:0] s1_tag;
    bit             s1_rdy;
    bit [XLEN-1:0]  s1_val;
    bit [TAG_W-1:0] s2_tag;
    bit             s2_rdy;
    bit [XLEN-1:0]  s2_val;
    bit             committed;
    bit             issued;
  } ent_t;

  ent_t mq[$];

  function automatic bit m_can_issue();
    if (mq.size() == 0) return 1'b0;
    return !mq[0].issued && mq[0].s1_rdy &&
           (mq[0].is_load || (mq[0].s2_rdy && mq[0].committed));
  endfunction

  function automatic bit cdb_find(input bit [TAG_W-1:0] t, output bit [XLEN-1:0] d);
    d = '0;
    for (int p = 0; p < CDB_PORTS; p++) begin
      if (cv[p] && (ct[p] == t)) begin
        d = cd[p];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    ent_t e;
    bit fire, ret, disp_ok;
    bit [XLEN-1:0] d;
    if (reset || flush) begin
      mq.delete();
    end else begin
      fire    = m_can_issue() && iss_ready;
      ret     = mem_done && (mq.size() > 0) && (mq[0].issued || fire);
      disp_ok = disp_valid && (mq.size() < DEPTH);
      for (int i = 0; i < mq.size(); i++) begin
        e = mq[i];
        if (!e.s1_rdy && cdb_find(e.s1_tag, d)) begin e.s1_rdy = 1'b1; e.s1_val = d; end
        if (!e.s2_rdy && cdb_find(e.s2_tag, d)) begin e.s2_rdy = 1'b1; e.s2_val = d; end
        if (commit_valid && !e.is_load && (e.tag == commit_tag)) e.committed = 1'b1;
        if ((i == 0) && fire) e.issued = 1'b1;
        mq[i] = e;
      end
      if (ret) void'(mq.pop_front());
      if (disp_ok) begin
        e.is_load   = disp_is_load;
        e.tag       = disp_tag;
        e.imm       = disp_imm;
        e.s1_tag    = disp_src1_tag;
        e.s1_rdy    = disp_src1_rdy;
        e.s1_val    = disp_src1_val;
        e.s2_tag    = disp_src2_tag;
        e.s2_rdy    = disp_src2_rdy || disp_is_load;
        e.s2_val    = disp_src2_val;
        e.committed = 1'b0;
        e.issued    = 1'b0;
        if (!e.s1_rdy && cdb_find(e.s1_tag, d)) begin e.s1_rdy = 1'b1; e.s1_val = d; end
        if (!e.s2_rdy && cdb_find(e.s2_tag, d)) begin e.s2_rdy = 1'b1; e.s2_val = d; end
        mq.push_back(e);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  always @(negedge clk) begin
    bit v;
    v = m_can_issue();
    checkOutput("disp_ready", disp_ready, mq.size() < DEPTH);
    checkOutput("count", count, mq.size());
    checkOutput("empty", empty, mq.size() == 0);
    checkOutput("iss_valid", iss_valid, v);
    if (v) begin
      checkOutput("iss_is_load", iss_is_load, mq[0].is_load);
      checkOutput("iss_tag", iss_tag, mq[0].tag);
      checkOutput("iss_addr", iss_addr, XLEN'(mq[0].s1_val + mq[0].imm));
      checkOutput("iss_data", iss_data, mq[0].is_load ? '0 : mq[0].s2_val);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; disp_valid = 0; disp_is_load = 0; disp_tag = '0; disp_imm = '0;
    disp_src1_tag = '0; disp_src1_rdy = 0; disp_src1_val = '0;
    disp_src2_tag = '0; disp_src2_rdy = 0; disp_src2_val = '0;
    commit_valid = 0; commit_tag = '0; iss_ready = 0; mem_done = 0;
    for (int p = 0; p < CDB_PORTS; p++) begin cv[p] = 0; ct[p] = '0; cd[p] = '0; end
  endtask

  task automatic drive_disp(input bit ld, input int tag, input int imm,
                            input int s1t, input bit s1r, input int s1v,
                            input int s2t, input bit s2r, input int s2v);
    disp_valid = 1; disp_is_load = ld; disp_tag = TAG_W'(tag); disp_imm = XLEN'(imm);
    disp_src1_tag = TAG_W'(s1t); disp_src1_rdy = s1r; disp_src1_val = XLEN'(s1v);
    disp_src2_tag = TAG_W'(s2t); disp_src2_rdy = s2r; disp_src2_val = XLEN'(s2v);
  endtask

  function automatic bit tag_in_queue(input bit [TAG_W-1:0] t);
    foreach (mq[i]) if (mq[i].tag == t) return 1'b1;
    return 1'b0;
  endfunction

  // One cycle of random traffic; dispatch tags stay unique within the queue.
  task automatic applyStimulus();
    bit [TAG_W-1:0] t;
    bit [TAG_W-1:0] stores[$];
    idle();
    flush = ($urandom_range(0, 149) == 0);
    if ($urandom_range(0, 1) == 1) begin
      do t = TAG_W'($urandom_range(0, (1 << TAG_W) - 1)); while (tag_in_queue(t));
      drive_disp($urandom_range(0, 1), t, $urandom,
                 $urandom_range(0, 7), $urandom_range(0, 1), $urandom,
                 $urandom_range(0, 7), $urandom_range(0, 1), $urandom);
    end
    for (int p = 0; p < CDB_PORTS; p++) begin
      cv[p] = ($urandom_range(0, 2) == 0);
      ct[p] = TAG_W'($urandom_range(0, 7));
      cd[p] = $urandom;
    end
    foreach (mq[i]) if (!mq[i].is_load) stores.push_back(mq[i].tag);
    if ((stores.size() > 0) && ($urandom_range(0, 3) == 0)) begin
      commit_valid = 1;
      commit_tag   = stores[$urandom_range(0, stores.size() - 1)];
    end
    iss_ready = $urandom_range(0, 1);
    mem_done  = ($urandom_range(0, 2) == 0);
  endtask

  initial begin
    idle();
    reset = 1;
    tick(); tick();
    reset = 0;
    checkOutput("rst_disp_ready", disp_ready, 1);
    checkOutput("rst_iss_valid", iss_valid, 0);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_iss_addr", iss_addr, 0);
    checkOutput("rst_iss_data", iss_data, 0);
    checkOutput("rst_iss_tag", iss_tag, 0);

    // Load straight after reset
    drive_disp(1, 3, 'h8, 0, 1, 'h100, 0, 0, 0);
    tick(); idle();
    checkOutput("ld_iss_valid", iss_valid, 1);
    checkOutput("ld_iss_addr", iss_addr, 'h108);
    checkOutput("ld_iss_is_load", iss_is_load, 1);
    iss_ready = 1; mem_done = 1;
    tick(); idle();
    checkOutput("ld_empty", empty, 1);

    // Store waits for commit
    drive_disp(0, 5, 'h4, 0, 1, 'h200, 0, 1, 'hDEAD);
    tick(); idle();
    for (int k = 0; k < 10; k++) begin
      checkOutput("st_hold_iss_valid", iss_valid, 0);
      tick();
    end
    commit_valid = 1; commit_tag = 5;
    tick(); idle();
    checkOutput("st_iss_valid", iss_valid, 1);
    checkOutput("st_iss_data", iss_data, 'hDEAD);
    checkOutput("st_iss_addr", iss_addr, 'h204);
    iss_ready = 1; mem_done = 1;
    tick(); idle();

    // Both operands woken by different ports in one cycle
    drive_disp(0, 6, 'h10, 7, 0, 0, 9, 0, 0);
    tick(); idle();
    commit_valid = 1; commit_tag = 6;
    tick(); idle();
    cv[0] = 1; ct[0] = 9; cd[0] = 'hAA;
    cv[1] = 1; ct[1] = 7; cd[1] = 'h40;
    tick(); idle();
    checkOutput("mp_iss_valid", iss_valid, 1);
    checkOutput("mp_iss_addr", iss_addr, 'h50);
    checkOutput("mp_iss_data", iss_data, 'hAA);
    iss_ready = 1; mem_done = 1;
    tick(); idle();

    // Broadcast concurrent with dispatch; port 0 outranks port 1
    drive_disp(1, 11, 'hC, 4, 0, 0, 0, 0, 0);
    cv[0] = 1; ct[0] = 4; cd[0] = 'h20;
    cv[1] = 1; ct[1] = 4; cd[1] = 'h99;
    tick(); idle();
    checkOutput("cc_iss_valid", iss_valid, 1);
    checkOutput("cc_iss_addr", iss_addr, 'h2C);
    iss_ready = 1; mem_done = 1;
    tick(); idle();

    // Fill, refuse, partially drain, refill across the wrap point
    for (int k = 0; k < DEPTH; k++) begin
      drive_disp(1, 10 + k, 0, 0, 1, k * 16, 0, 0, 0);
      tick();
    end
    idle();
    checkOutput("full_disp_ready", disp_ready, 0);
    checkOutput("full_count", count, DEPTH);
    drive_disp(1, 30, 0, 0, 1, 0, 0, 0, 0);
    tick(); idle();
    checkOutput("full_drop_count", count, DEPTH);
    for (int k = 0; k < 3; k++) begin
      checkOutput("wrap_head_tag", iss_tag, 10 + k);
      iss_ready = 1; mem_done = 1;
      if (k == 0) drive_disp(1, 31, 0, 0, 1, 0, 0, 0, 0);
      tick(); idle();
      if (k == 0) checkOutput("full_done_disp_count", count, DEPTH - 1);
    end
    for (int k = 0; k < 3; k++) begin
      drive_disp(1, 18 + k, 0, 0, 1, k, 0, 0, 0);
      tick();
    end
    idle();
    checkOutput("refill_count", count, DEPTH);
    for (int k = 0; k < DEPTH; k++) begin
      checkOutput("drain_iss_valid", iss_valid, 1);
      checkOutput("drain_iss_tag", iss_tag, 13 + k);
      iss_ready = 1; mem_done = 1;
      tick(); idle();
    end
    checkOutput("drain_empty", empty, 1);

    // Flush with an issued head and a pending mem_done
    drive_disp(1, 1, 0, 0, 1, 0, 0, 0, 0);
    tick(); idle();
    iss_ready = 1;
    tick(); idle();
    flush = 1;
    tick(); idle();
    checkOutput("fl_count", count, 0);
    checkOutput("fl_iss_valid", iss_valid, 0);
    mem_done = 1;
    tick(); idle();
    checkOutput("fl_late_done_count", count, 0);
    drive_disp(1, 2, 0, 0, 1, 'h10, 0, 0, 0);
    tick(); idle();
    checkOutput("fl_after_iss_valid", iss_valid, 1);
    checkOutput("fl_after_iss_tag", iss_tag, 2);
    iss_ready = 1; mem_done = 1;
    tick(); idle();

    for (int n = 0; n < 4000; n++) begin
      applyStimulus();
      tick();
    end
    idle();
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
